// File: rtl/program_byte_assembler.sv
// Framed byte-stream to 16-bit word assembler for the program loader.
// Words are presented as one continuous write burst, and the frame ends with an XOR checksum check.
module program_byte_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] data_out,
  output logic [4:0]  addr_out,
  output logic        write_enable_out,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_HI,
    S_RX_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  acc_q, acc_d;
  logic [15:0] data_q, data_d;
  logic [4:0]  addr_q, addr_d;
  logic        we_q, we_d;

  logic        accept;
  logic        header_legal;

  assign byte_ready   = (state_q != S_DONE) && (state_q != S_ERROR);
  assign accept       = byte_valid && byte_ready;
  assign header_legal = (byte_in[7:6] == 2'b00) && (byte_in[5:0] != 6'd0) &&
                        (byte_in[5:0] <= 6'd32);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= 6'd0;
      idx_q   <= 6'd0;
      hi_q    <= 8'd0;
      acc_q   <= 8'd0;
      data_q  <= 16'd0;
      addr_q  <= 5'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (header_legal) begin
            count_d = byte_in[5:0];
            idx_d   = 6'd0;
            acc_d   = 8'd0;
            state_d = S_RX_HI;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_RX_HI: begin
        // Strobe is held between words so the burst stays unbroken.
        we_d = we_q;
        if (accept) begin
          hi_d    = byte_in;
          acc_d   = acc_q ^ byte_in;
          state_d = S_RX_LO;
        end
      end
      S_RX_LO: begin
        we_d = we_q;
        if (accept) begin
          data_d  = {hi_q, byte_in};
          addr_d  = idx_q[4:0];
          we_d    = 1'b1;
          acc_d   = acc_q ^ byte_in;
          idx_d   = idx_q + 6'd1;
          state_d = ((idx_q + 6'd1) == count_q) ? S_CHECK : S_RX_HI;
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (byte_in == acc_q) ? S_DONE : S_ERROR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  assign data_out         = data_q;
  assign addr_out         = addr_q;
  assign write_enable_out = we_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign error            = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_byte_assembler.sv
// Directed bench for program_byte_assembler: expected words are queued as the
// low byte is driven and popped once the DUT presents them.
module tb_program_byte_assembler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [15:0] data_out;
  logic [4:0]  addr_out;
  logic        write_enable_out;
  logic        busy;
  logic        done;
  logic        error;

  program_byte_assembler dut (
    .clock            (clock),
    .reset            (reset),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .data_out         (data_out),
    .addr_out         (addr_out),
    .write_enable_out (write_enable_out),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Free-running monitors; the bench only takes differences of these.
  int   we_hi_cnt = 0;
  int   we_fall_cnt = 0;
  int   done_cnt = 0;
  logic we_prev = 1'b0;

  always @(negedge clock) begin
    if (write_enable_out) we_hi_cnt++;
    if (done) done_cnt++;
    if (we_prev && !write_enable_out) we_fall_cnt++;
    we_prev = write_enable_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd1);
    check({tag, "_data"}, {16'd0, data_out}, 32'd0);
    check({tag, "_addr"}, {27'd0, addr_out}, 32'd0);
    check({tag, "_we"}, {31'd0, write_enable_out}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  // Offer one byte after 'gap' idle cycles; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    for (int k = 0; k < gap; k++) begin
      @(negedge clock);
      byte_valid = 1'b0;
    end
    @(negedge clock);
    byte_in    = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 20 && !byte_ready; t++) @(negedge clock);
    if (!byte_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clock);
      #1;
    end
    byte_valid = 1'b0;
    $display("tb: byte 0x%02h offered, busy=%0b we=%0b", b, busy, write_enable_out);
  endtask

  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input logic [4:0] a, input int gap);
    exp_t e;
    send(hi, gap);
    exp_q.push_back({a, hi, lo});
    send(lo, gap);
    e = exp_q.pop_front();
    check("word_data", {16'd0, data_out}, {16'd0, e.d});
    check("word_addr", {27'd0, addr_out}, {27'd0, e.a});
    check("word_we", {31'd0, write_enable_out}, 32'd1);
    $display("tb: word addr=%0d data=0x%04h (expected %0d/0x%04h)", addr_out, data_out, e.a, e.d);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check_reset_values("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int we0, fall0, done0;
    logic [7:0] hdr [3];

    // Reset state
    repeat (2) @(negedge clock);
    check_reset_values("por");
    reset = 1'b0;

    // Good N=2 frame, back-to-back
    we0 = we_hi_cnt; done0 = done_cnt;
    send(8'h02, 0);
    send_word(8'h12, 8'h34, 5'd0, 0);
    send_word(8'hAB, 8'hCD, 5'd1, 0);
    send(8'h40, 0);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_we_low", {31'd0, write_enable_out}, 32'd0);
    @(posedge clock); #1;
    check("t1_done_fall", {31'd0, done}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    check("t1_we_cycles", we_hi_cnt - we0, 32'd3);
    check("t1_done_pulses", done_cnt - done0, 32'd1);
    check("t1_error", {31'd0, error}, 32'd0);

    // Bad checksum: words still written, error sticky, further bytes ignored
    send(8'h02, 0);
    send_word(8'h12, 8'h34, 5'd0, 0);
    send_word(8'hAB, 8'hCD, 5'd1, 0);
    send(8'h41, 0);
    check("t2_error", {31'd0, error}, 32'd1);
    check("t2_ready", {31'd0, byte_ready}, 32'd0);
    @(negedge clock);
    byte_in = 8'h01; byte_valid = 1'b1;
    repeat (4) @(negedge clock);
    byte_valid = 1'b0;
    check("t2_error_sticky", {31'd0, error}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_we", {31'd0, write_enable_out}, 32'd0);
    check("t2_data_held", {16'd0, data_out}, 32'h0000ABCD);
    pulse_reset();

    // Illegal headers
    hdr[0] = 8'h00; hdr[1] = 8'h21; hdr[2] = 8'h41;
    for (int h = 0; h < 3; h++) begin
      we0 = we_hi_cnt;
      send(hdr[h], 0);
      check("t3_error", {31'd0, error}, 32'd1);
      @(posedge clock); #1;
      check("t3_we_never", we_hi_cnt - we0, 32'd0);
      pulse_reset();
    end

    // N=32, byte i = i, random gaps; burst must not break
    fall0 = we_fall_cnt; done0 = done_cnt;
    send(8'h20, 0);
    for (int w = 0; w < 32; w++)
      send_word(8'(2 * w), 8'(2 * w + 1), 5'(w), int'($urandom_range(0, 2)));
    check("t4_we_during", we_fall_cnt - fall0, 32'd0);
    send(8'h00, int'($urandom_range(0, 2)));
    check("t4_done", {31'd0, done}, 32'd1);
    @(posedge clock); #1;
    check("t4_we_one_fall", we_fall_cnt - fall0, 32'd1);
    check("t4_done_pulses", done_cnt - done0, 32'd1);

    // Asynchronous reset mid-frame, then a fresh N=1 frame
    send(8'h04, 0);
    send_word(8'h11, 8'h22, 5'd0, 0);
    send(8'h33, 0);
    #2;
    pulse_reset();
    done0 = done_cnt;
    send(8'h01, 0);
    send_word(8'h5A, 8'h3C, 5'd0, 0);
    send(8'h66, 0);
    check("t5_done", {31'd0, done}, 32'd1);

    // Two good frames back-to-back
    @(posedge clock); #1;
    done0 = done_cnt;
    send(8'h01, 0);
    send_word(8'hBE, 8'hEF, 5'd0, 0);
    send(8'h51, 0);
    send(8'h01, 0);
    send_word(8'h00, 8'h01, 5'd0, 0);
    send(8'h01, 0);
    @(posedge clock); #1;
    check("t6_done_pulses", done_cnt - done0, 32'd2);
    check("t6_error", {31'd0, error}, 32'd0);
    check("t6_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_byte_assembler.md
# program_byte_assembler

Upstream feeder for the program loader. Accepts a framed byte stream (host/UART side) over a valid/ready handshake, assembles big-endian 16-bit instruction words, and assigns sequential 5-bit addresses. Drives the loader's `data_in`/`addr`/`write_enable` inputs as one continuous burst. Verifies a trailing XOR checksum and reports completion or error.

## Interface
Parameters: none; all widths fixed.

Ports:
- `clock`  in  1  system clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` valid this cycle.
- `byte_ready`  out  1  block can accept a byte this cycle.
- `data_out`  out  16  assembled word; connects to loader `data_in`.
- `addr_out`  out  5  word address; connects to loader `addr`.
- `write_enable_out`  out  1  burst-active strobe; connects to loader `write_enable`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse on a good frame.
- `error`  out  1  sticky frame error.

## Operation
- Handshake: a byte is accepted on a rising edge when `byte_valid && byte_ready`. `byte_ready` is combinational from state only: 1 in IDLE, RX_HI, RX_LO and CHECK; 0 in DONE and ERROR.
- Frame format: header byte N, then 2N data bytes (high byte first per word), then 1 checksum byte.
- N is legal when `byte_in[7:6]==0` and `byte_in[5:0]` is in 1..32. Any other value goes to ERROR.
- Checksum = XOR of all 2N data bytes. The header is excluded.

State machine (all registered):
- IDLE: on accepting a legal N, latch count, clear word index and checksum accumulator, go to RX_HI. On an illegal N, go to ERROR.
- RX_HI: on accept, latch high byte and XOR it into the accumulator. Go to RX_LO.
- RX_LO: on accept:
  - `data_out <= {hi, byte_in}`, `addr_out <=` word index, `write_enable_out <= 1`.
  - XOR the byte into the accumulator and increment the index.
  - If this was the last word, go to CHECK; otherwise go to RX_HI.
- CHECK: `write_enable_out` clears on entry (the edge after the last word). On accept:
  - byte equals accumulator: go to DONE.
  - byte differs: go to ERROR.
- DONE: `done=1` for exactly one cycle, then IDLE.
- ERROR: `error=1` and `byte_ready=0`; held until `reset`. Words already written are not rolled back.

Output rules:
- `busy` = (state != IDLE).
- Word index is 6 bits internally; `addr_out` is its low 5 bits. Word i always has address i (0..N-1), with no wrap because N ≤ 32.
- `write_enable_out` stays high continuously from the first word's low-byte edge through the last word's low-byte edge. Between words, `data_out`/`addr_out` hold the previous word; repeated identical writes downstream are harmless by design.

## Timing
- Reset values: `byte_ready=1`, `data_out=0`, `addr_out=0`, `write_enable_out=0`, `busy=0`, `done=0`, `error=0`; state IDLE.
- `reset` mid-frame returns to IDLE immediately (asynchronous), with `write_enable_out` low at once. The partial frame is discarded.
- Latency: a word is presented on the same edge that accepts its low byte. `write_enable_out` falls 1 cycle after the last word is presented.
- `done` rises on the edge that accepts a matching checksum and falls on the next edge. The earliest next header is accepted in the cycle after `done`.
- Back-to-back bytes (`byte_valid` held high) sustain 1 byte/cycle, so a new word arrives every 2 cycles.
- Gaps in `byte_valid` stretch the burst; the state is held with no timeout.
- `byte_valid` while `byte_ready=0` (DONE/ERROR) is ignored and the byte is not consumed.

## Test plan
- Frame N=2, bytes 12 34 AB CD, checksum 0x12^0x34^0xAB^0xCD=0x40, streamed back-to-back -> `write_enable_out` high for 3 cycles; words (0,0x1234) then (1,0xABCD); `done` pulses once; `error`=0.
- Same frame with the checksum byte changed to 0x41 -> both words still presented; `error`=1 and sticky, `byte_ready`=0; a following header is ignored until `reset`.
- Header 0x00, then separately header 0x21 (33), then separately 0x41 -> each goes to ERROR after the header; `write_enable_out` never asserts.
- N=32 with 64 data bytes where byte i = i (checksum 0x00), with random `byte_valid` gaps -> addresses 0..31 in order; `write_enable_out` unbroken through word 31; `done` pulses.
- `reset` asserted after the 3rd data byte of an N=4 frame -> all outputs at reset values asynchronously; a fresh N=1 frame then completes normally at address 0.
- Two good frames back-to-back (N=1 data 0xBEEF checksum 0x51, then N=1 data 0x0001 checksum 0x01) -> two `done` pulses; both words are written to address 0 in order.
